// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, credit-limits memory requests, and buffers responses in an in-order prefetch FIFO.
// A response written in cycle N is presented in cycle N+1. The consumer stalls via instr_ready_i; a full FIFO plus in-flight requests stops new requests.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          ack;
    logic          stale;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [CW-1:0] outstanding_next;
    logic [31:0]   redirect_target;
    logic          unused_bits;

    // Buffered entries plus in-flight requests never exceed DEPTH, so every response has a slot.
    assign credit_used      = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_o       = !rst_i && !redirect_i && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr_o      = fetch_pc;
    assign ack              = imem_req_o && imem_ack_i;
    assign stale            = imem_rvalid_i && (discard != '0);
    assign push             = imem_rvalid_i && (discard == '0) && !redirect_i;
    assign pop              = instr_valid_o && instr_ready_i;
    assign outstanding_next = outstanding + CW'(ack) - CW'(imem_rvalid_i);
    assign redirect_target  = {redirect_pc_i[31:2], 2'b00};
    assign unused_bits      = ^redirect_pc_i[1:0];

    assign instr_valid_o = !rst_i && (count != '0);
    assign instr_o       = instr_mem[rd_ptr];
    assign pc_o          = pc_mem[rd_ptr];
    assign pc_plus4_o    = pc_o + 32'd4;

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            instr_mem[wr_ptr] <= imem_rdata_i;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_i) begin
                // Every request still in flight after this edge belongs to the old stream.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                discard  <= outstanding_next;
            end else begin
                if (ack) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (stale) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] target;
        int          ready_pct;
        int          ack_pct;
        int          lat_min;
        int          lat_max;
        int          cycles;
        logic [31:0] exp_first_pc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        ack_in;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    bit          sel;

    logic        req_a, valid_a, req_b, valid_b;
    logic [31:0] addr_a, instr_a, pc_a, pc4_a, addr_b, instr_b, pc_b, pc4_b;
    logic        m_req, m_valid;
    logic [31:0] m_addr, m_instr, m_pc, m_pc4;

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req_a), .imem_addr_o(addr_a), .imem_ack_i(ack_in),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .instr_valid_o(valid_a), .instr_o(instr_a), .pc_o(pc_a), .pc_plus4_o(pc4_a),
        .instr_ready_i(ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
    );

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(WRAP_PC)) u_wrap (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req_b), .imem_addr_o(addr_b), .imem_ack_i(ack_in),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .instr_valid_o(valid_b), .instr_o(instr_b), .pc_o(pc_b), .pc_plus4_o(pc4_b),
        .instr_ready_i(ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
    );

    assign m_req   = sel ? req_b   : req_a;
    assign m_valid = sel ? valid_b : valid_a;
    assign m_addr  = sel ? addr_b  : addr_a;
    assign m_instr = sel ? instr_b : instr_a;
    assign m_pc    = sel ? pc_b    : pc_a;
    assign m_pc4   = sel ? pc4_b   : pc4_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    int          cyc;
    logic [31:0] exp_fetch_pc;
    logic [31:0] sb_q[$];
    mreq_t       mq[$];
    bit          first_pending;
    logic [31:0] first_exp;
    bit          ev_hs, ev_ack, ev_rv, ev_valid;
    logic [31:0] ev_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1; ack_in = 1'b0; rvalid = 1'b0; rdata = '0;
            ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
            #1;
            chk("rst_req", 32'(m_req), 32'd0);
            chk("rst_valid", 32'(m_valid), 32'd0);
        end
        mq.delete();
        sb_q.delete();
        first_pending = 1'b0;
        exp_fetch_pc  = sel ? WRAP_PC : 32'h0000_0000;
        cyc = 0;
    endtask

    // One clock of stimulus; memory and scoreboard model update for the coming edge.
    task automatic step(input bit rdy, input bit ak, input bit redir, input logic [31:0] rpc,
                        input int lmin, input int lmax);
        @(negedge clk);
        rst = 1'b0;
        rvalid = 1'b0;
        rdata = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        ready = rdy; ack_in = ak; redirect = redir; redirect_pc = rpc;
        #1;
        ev_valid = m_valid;
        ev_hs    = m_valid && rdy;
        ev_ack   = m_req && ak;
        ev_rv    = rvalid;
        ev_pc    = m_pc;
        if (redir) chk("req_during_redirect", 32'(m_req), 32'd0);
        if (m_valid) chk("pc_plus4", m_pc4, m_pc + 32'd4);
        if (ev_hs) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_instr_pc", m_pc, 32'hDEAD_BEEF);
            end else begin
                logic [31:0] e;
                e = sb_q.pop_front();
                chk("instr_pc", m_pc, e);
                chk("instr_data", m_instr, mem_word(e));
            end
            if (first_pending) begin
                chk("first_pc_after_redirect", m_pc, first_exp);
                first_pending = 1'b0;
            end
        end
        if (ev_ack) begin
            mreq_t r;
            chk("req_addr", m_addr, exp_fetch_pc);
            sb_q.push_back(exp_fetch_pc);
            r.addr = m_addr;
            r.due  = cyc + $urandom_range(lmax, lmin);
            mq.push_back(r);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        if (redir) begin
            sb_q.delete();
            exp_fetch_pc  = {rpc[31:2], 2'b00};
            first_pending = 1'b1;
        end
        cyc++;
    endtask

    vec_t        vecs[5];
    logic [31:0] seq_exp[4];
    logic [31:0] seen[4];
    logic [31:0] wrap_exp[3];

    initial begin
        int first_v, n, cnt;
        checks = 0; failures = 0; sel = 1'b0; cyc = 0;
        rst = 1'b1; ack_in = 1'b0; rvalid = 1'b0; rdata = '0;
        ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        first_exp = '0; first_pending = 1'b0;

        vecs[0] = '{32'h0000_0103, 100, 100, 1, 1, 40, 32'h0000_0100};
        vecs[1] = '{32'h0000_2002,  50,  70, 1, 3, 60, 32'h0000_2000};
        vecs[2] = '{32'h1234_5679,  30, 100, 2, 5, 80, 32'h1234_5678};
        vecs[3] = '{32'hFFFF_FFF3,  80,  60, 1, 2, 60, 32'hFFFF_FFF0};
        vecs[4] = '{32'h0000_0040, 100,  40, 1, 4, 60, 32'h0000_0040};
        seq_exp  = '{32'h0, 32'h4, 32'h8, 32'hC};
        wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

        // First instruction after reset release with immediate ack and 1-cycle memory.
        do_reset(3);
        first_v = -1; n = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 0, '0, 1, 1);
            if (ev_valid && first_v < 0) first_v = k;
            if (ev_hs && n < 4) begin seen[n] = ev_pc; n++; end
        end
        chk("first_valid_cycle", 32'(first_v), 32'd2);
        for (int i = 0; i < 4; i++) chk("reset_pc_seq", seen[i], seq_exp[i]);

        // Back-pressure: credit stops requests at DEPTH, then full rate once released.
        do_reset(2);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0, '0, 1, 1);
            if (ev_ack) cnt++;
        end
        chk("bp_ack_count", 32'(cnt), 32'd4);
        chk("bp_req_stopped", 32'(m_req), 32'd0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 0, '0, 1, 1);
            if (ev_hs) cnt++;
        end
        chk("bp_release_rate", 32'(cnt), 32'd8);

        // Redirect with three requests outstanding.
        do_reset(2);
        for (int k = 0; k < 3; k++) step(1, 1, 0, '0, 6, 6);
        step(1, 0, 0, '0, 6, 6);
        first_exp = 32'h0000_0100;
        step(1, 1, 1, 32'h0000_0103, 6, 6);
        cnt = 0; first_v = 0;
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 0, '0, 6, 6);
            if (ev_valid) first_v = 1;
            if (ev_rv && !first_v) cnt++;
        end
        chk("rvalids_before_new_stream", 32'(cnt), 32'd4);
        chk("redirect_3_pending_done", 32'(first_pending), 32'd0);

        // Redirect coinciding with an ack request and a head handshake.
        do_reset(2);
        for (int k = 0; k < 5; k++) step(1, 1, 0, '0, 1, 1);
        first_exp = 32'h0000_0200;
        step(1, 1, 1, 32'h0000_0200, 1, 1);
        chk("redirect_cycle_handshake", 32'(ev_hs), 32'd1);
        for (int k = 0; k < 12; k++) step(1, 1, 0, '0, 1, 1);
        chk("redirect_hs_pending_done", 32'(first_pending), 32'd0);

        // Second redirect while the first is still discarding.
        do_reset(2);
        for (int k = 0; k < 3; k++) step(1, 1, 0, '0, 6, 6);
        step(1, 0, 0, '0, 6, 6);
        first_exp = 32'h0000_0300;
        step(1, 1, 1, 32'h0000_0300, 6, 6);
        step(1, 1, 0, '0, 6, 6);
        step(1, 1, 0, '0, 6, 6);
        first_exp = 32'h0000_0400;
        step(1, 1, 1, 32'h0000_0400, 6, 6);
        for (int k = 0; k < 25; k++) step(1, 1, 0, '0, 6, 6);
        chk("double_redirect_pending_done", 32'(first_pending), 32'd0);

        // Table-driven redirects under random ready/ack/latency.
        do_reset(2);
        for (int v = 0; v < 5; v++) begin
            first_exp = vecs[v].exp_first_pc;
            step(1, 1, 1, vecs[v].target, vecs[v].lat_min, vecs[v].lat_max);
            for (int k = 0; k < vecs[v].cycles; k++)
                step($urandom_range(99, 0) < vecs[v].ready_pct,
                     $urandom_range(99, 0) < vecs[v].ack_pct,
                     0, '0, vecs[v].lat_min, vecs[v].lat_max);
            for (int k = 0; k < 20; k++) step(1, 1, 0, '0, vecs[v].lat_min, vecs[v].lat_max);
            chk("vec_first_instr_seen", 32'(first_pending), 32'd0);
        end

        // Sequential fetch across the top of the address space from a high reset PC.
        sel = 1'b1;
        do_reset(2);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 0, '0, 1, 1);
            if (ev_hs && n < 3) begin seen[n] = ev_pc; n++; end
        end
        for (int i = 0; i < 3; i++) chk("wrap_pc_seq", seen[i], wrap_exp[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
